ofmap_acc_mem: RTL
==================

# ofmap_acc_mem

Parametrised, banked output-feature-map memory; the next generation of the fixed 4×128-bit ofmap store. It sits between the systolic array's drain path and the output writeback. It adds per-bank write masking, an accumulate-on-write mode for partial-sum reduction across input-channel tiles, lane-wise wrap or saturating arithmetic, read-valid signalling, and a hardware clear sequencer that zeroes the array after reset or on request.

## Interface
- NUM_BANKS, 4, number of independent banks; total data width = NUM_BANKS*BANK_W
- BANK_W, 128, bits per bank; must be a multiple of ELEM_W
- ELEM_W, 8, lane width for accumulate arithmetic
- DEPTH, 1024, entries per bank
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH
- SAT, 0, 0 = wrap-around lane add, 1 = signed saturating lane add
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- clr_start  in  1  request a full clear; sampled only in READY
- ready  out  1  high when reads and writes are accepted
- wren  in  1  write request
- acc  in  1  qualifies wren: 1 = accumulate into stored value, 0 = overwrite
- bank_en  in  NUM_BANKS  per-bank write mask
- wraddress  in  ADDR_W  write address
- data  in  NUM_BANKS*BANK_W  write data; bank b = data[b*BANK_W +: BANK_W]
- rd_en  in  1  read request
- rdaddress  in  ADDR_W  read address
- q  out  NUM_BANKS*BANK_W  registered read data
- rd_valid  out  1  q holds the result of the read issued the previous cycle

## Operation
- FSM states: CLEAR and READY. Reset enters CLEAR with clear counter = 0.
- CLEAR: each cycle, write 0 to all banks at the counter address, then increment. After address DEPTH-1, go to READY. Duration is exactly DEPTH cycles. ready=0. wren, rd_en and clr_start are ignored and not queued.
- READY: ready=1. clr_start=1 moves the FSM to CLEAR at the next edge with counter = 0.
  - An in-flight write commit still completes on that same edge, before the clear overwrites it.
  - A request accepted in the same cycle as clr_start is accepted normally.
- Write pipeline, applied to both modes:
  - Stage W0 (accept cycle N) captures wraddress, data, bank_en and acc, and issues an internal read of wraddress.
  - Stage W1 (cycle N+1) computes the result and commits it on the edge ending N+1.
- Write result per bank:
  - bank_en[b]=0: bank b is unchanged.
  - Overwrite: new = data.
  - Accumulate: each ELEM_W lane is computed as stored + data, independently per lane with no carry between lanes. SAT=0 wraps modulo 2^ELEM_W. SAT=1 clamps to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
- Forwarding: if W1 commits to address A and W0 accepts an accumulate to A in the same cycle, W0 uses W1's result as the stored value, merged per bank by W1's bank_en. Back-to-back accumulates to one address must therefore sum correctly every cycle.
- Read: rd_en at cycle N returns mem[rdaddress] on q at N+1 with rd_valid=1.
  - Read-during-commit to the same address returns the pre-commit (old) value.
  - Without rd_en, rd_valid=0 and q holds its last value.
- Addresses >= DEPTH: the write is dropped and the read returns 0 with rd_valid=1.

## Timing
- Reset values: ready=0, rd_valid=0, q=0, W0/W1 valid=0, FSM=CLEAR, counter=0.
- reset asserted mid-operation: any pending W1 commit is discarded. The clear restarts from address 0 on the cycle after reset deasserts.
- First accepted access occurs DEPTH cycles after reset deasserts (ready rises on cycle DEPTH).
- Read latency is 1 cycle. Write visible to reads issued 2 cycles after acceptance (N+2). Sustained throughput is one read plus one write per cycle.
- Simultaneous wren and rd_en are allowed in the same cycle. A clear write and a W1 commit never coincide.

## Test plan
- Reset, then hold 1024 cycles, then read all addresses (DEPTH=1024) -> ready rises on cycle 1024 and every q=0.
- Overwrite addr 5 with 0x01..40 pattern, bank_en=4'b0101, then read 5 -> banks 0 and 2 hold the pattern, banks 1 and 3 read 0.
- Accumulate lanes of 0x7F then 0x02 back-to-back to addr 9 -> SAT=0 lane = 0x81; SAT=1 lane = 0x7F. Also 0x80 + 0xFF with SAT=1 -> 0x80.
- Four consecutive accumulates of 1 to addr 3, read at N+5 -> every lane = 4, proving forwarding.
- Read addr 7 in the commit cycle of a write of 0xAA to addr 7 -> returns old 0x00; the next read returns 0xAA.
- clr_start after writing addr 2, and separately reset asserted mid-clear -> ready drops for 1024 cycles, then addr 2 reads 0; during the clear, rd_en yields rd_valid=0.

Source files
------------

// File: rtl/ofmap_acc_mem.sv
// Banked output-feature-map store: masked overwrite/accumulate writes through a two-stage
// read-modify-write pipeline, one-cycle registered reads, and a sequencer that zeroes every entry.
module ofmap_acc_mem #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BANK_W    = 128,
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SAT       = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clr_start,
    output logic                        ready,
    input  logic                        wren,
    input  logic                        acc,
    input  logic [NUM_BANKS-1:0]        bank_en,
    input  logic [ADDR_W-1:0]           wraddress,
    input  logic [NUM_BANKS*BANK_W-1:0] data,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rdaddress,
    output logic [NUM_BANKS*BANK_W-1:0] q,
    output logic                        rd_valid
);
    localparam int unsigned DATA_W = NUM_BANKS * BANK_W;
    localparam int unsigned LANES  = DATA_W / ELEM_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ELEM_W-1:0] LANE_MAX  = {1'b0, {(ELEM_W - 1){1'b1}}};
    localparam logic [ELEM_W-1:0] LANE_MIN  = {1'b1, {(ELEM_W - 1){1'b0}}};

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    q_q, q_d;
    logic                 w1_vld_q, w1_vld_d;
    logic                 w1_acc_q, w1_acc_d;
    logic [NUM_BANKS-1:0] w1_be_q, w1_be_d;
    logic [ADDR_W-1:0]    w1_addr_q, w1_addr_d;
    logic [DATA_W-1:0]    w1_data_q, w1_data_d;
    logic [DATA_W-1:0]    w1_stored_q, w1_stored_d;

    logic [DATA_W-1:0]    w1_result_c, rd_word_c, wr_word_c;
    logic [ELEM_W:0]      lane_sum_c;
    logic                 clr_we_c, commit_c, wr_ok_c, rd_ok_c;

    // One storage array per bank so a masked bank is never rewritten.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [BANK_W-1:0] mem_q [DEPTH];

        always_ff @(posedge clock) begin
            if (clr_we_c) begin
                mem_q[cnt_q] <= '0;
            end else if (commit_c && w1_be_q[b]) begin
                mem_q[w1_addr_q] <= w1_result_c[b*BANK_W +: BANK_W];
            end
        end

        assign rd_word_c[b*BANK_W +: BANK_W] = mem_q[rdaddress];
        assign wr_word_c[b*BANK_W +: BANK_W] = mem_q[wraddress];
    end

    // Clear sequencer / access gate.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_c = !reset;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_READY);
    end

    // W0 capture with forwarding from the W1 commit, plus the read port.
    always_comb begin
        wr_ok_c     = ({1'b0, wraddress} < DEPTH_L);
        rd_ok_c     = ({1'b0, rdaddress} < DEPTH_L);
        commit_c    = w1_vld_q && (state_q == ST_READY) && !reset;
        w1_vld_d    = (state_q == ST_READY) && wren && wr_ok_c;
        w1_acc_d    = w1_acc_q;
        w1_be_d     = w1_be_q;
        w1_addr_d   = w1_addr_q;
        w1_data_d   = w1_data_q;
        w1_stored_d = w1_stored_q;
        if (w1_vld_d) begin
            w1_acc_d    = acc;
            w1_be_d     = bank_en;
            w1_addr_d   = wraddress;
            w1_data_d   = data;
            w1_stored_d = wr_word_c;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w1_vld_q && (w1_addr_q == wraddress) && w1_be_q[b]) begin
                    w1_stored_d[b*BANK_W +: BANK_W] = w1_result_c[b*BANK_W +: BANK_W];
                end
            end
        end
        rd_valid_d = (state_q == ST_READY) && rd_en;
        q_d        = q_q;
        if (rd_valid_d) begin
            q_d = rd_ok_c ? rd_word_c : '0;
        end
    end

    // W1 lane arithmetic; lanes never carry into each other.
    always_comb begin
        w1_result_c = w1_data_q;
        lane_sum_c  = '0;
        if (w1_acc_q) begin
            for (int l = 0; l < LANES; l++) begin
                lane_sum_c = {w1_stored_q[l*ELEM_W + ELEM_W - 1], w1_stored_q[l*ELEM_W +: ELEM_W]}
                           + {w1_data_q[l*ELEM_W + ELEM_W - 1], w1_data_q[l*ELEM_W +: ELEM_W]};
                if ((SAT != 0) && (lane_sum_c[ELEM_W] != lane_sum_c[ELEM_W-1])) begin
                    w1_result_c[l*ELEM_W +: ELEM_W] = lane_sum_c[ELEM_W] ? LANE_MIN : LANE_MAX;
                end else begin
                    w1_result_c[l*ELEM_W +: ELEM_W] = lane_sum_c[ELEM_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            q_q        <= '0;
            w1_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            q_q        <= q_d;
            w1_vld_q   <= w1_vld_d;
        end
    end

    // Write payload needs no reset; it is qualified by w1_vld_q.
    always_ff @(posedge clock) begin
        w1_acc_q    <= w1_acc_d;
        w1_be_q     <= w1_be_d;
        w1_addr_q   <= w1_addr_d;
        w1_data_q   <= w1_data_d;
        w1_stored_q <= w1_stored_d;
    end

    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign q        = q_q;

endmodule
